bcd_to_bin_seq: RTL and testbench

- Sequential multi-digit BCD-to-binary converter using reverse double-dabble (shift right, then subtract 3 from any nibble >= 8).
- Inverse of the adder/display path, which splits a binary sum into tens/ones digits. This block takes decimal digits entered on switches and rebuilds the binary value for arithmetic.
- Start/busy/done handshake; one digit-validity error flag.

---
 rtl/bcd_to_bin_seq.sv | 128 ++++++++++++
 tb/tb_bcd_to_bin_seq.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/bcd_to_bin_seq.sv
// Sequential BCD-to-binary converter (reverse double-dabble), one bit per cycle.
// Optional macro BCD2BIN_CARRY_IN_EN adds a Cin port whose value is added to the result.
module bcd_to_bin_seq #(
  parameter int DIGITS = 2,
  parameter int BIN_W  = 7
) (
  input  logic                  Clock,
  input  logic                  Resetn,
  input  logic                  Start,
  input  logic [4*DIGITS-1:0]   BCD,
`ifdef BCD2BIN_CARRY_IN_EN
  input  logic                  Cin,
`endif
  output logic [BIN_W-1:0]      Bin,
  output logic                  Busy,
  output logic                  Done,
  output logic                  Err,
  output logic [1:0]            dbg_state
);

  localparam int SR_W  = 4*DIGITS + BIN_W;
  localparam int CNT_W = $clog2(BIN_W + 1);

  // Handshake: Start is sampled only in IDLE; Busy covers the SHIFT cycles;
  // Done is a one-cycle pulse that coincides with Bin/Err becoming valid.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t             state, state_next;
  logic [SR_W-1:0]    sr;
  logic [SR_W-1:0]    sr_sh;
  logic [SR_W-1:0]    sr_next;
  logic [CNT_W-1:0]   cnt;
  logic               digit_bad;
  logic               last_shift;
  logic [BIN_W-1:0]   result;

`ifdef BCD2BIN_CARRY_IN_EN
  logic               cin_q;
  assign result = sr[BIN_W-1:0] + BIN_W'(cin_q);
`else
  assign result = sr[BIN_W-1:0];
`endif

  assign dbg_state  = state;
  assign last_shift = (cnt == CNT_W'(BIN_W - 1));

  always_comb begin
    digit_bad = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (BCD[4*i +: 4] > 4'd9) digit_bad = 1'b1;
    end
  end

  // One reverse double-dabble step: shift right, then pull each BCD nibble back below 8.
  always_comb begin
    sr_sh   = sr >> 1;
    sr_next = sr_sh;
    for (int i = 0; i < DIGITS; i++) begin
      if (sr_sh[BIN_W + 4*i +: 4] >= 4'd8)
        sr_next[BIN_W + 4*i +: 4] = sr_sh[BIN_W + 4*i +: 4] - 4'd3;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (Start) state_next = digit_bad ? DONE : SHIFT;
      SHIFT:   if (last_shift) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) state <= IDLE;
    else         state <= state_next;
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      sr    <= '0;
      cnt   <= '0;
      Bin   <= '0;
      Busy  <= 1'b0;
      Done  <= 1'b0;
      Err   <= 1'b0;
`ifdef BCD2BIN_CARRY_IN_EN
      cin_q <= 1'b0;
`endif
    end else begin
      Done <= 1'b0;
      case (state)
        IDLE: begin
          if (Start) begin
            sr <= {BCD, {BIN_W{1'b0}}};
`ifdef BCD2BIN_CARRY_IN_EN
            cin_q <= Cin;
`endif
            if (digit_bad) begin
              Err <= 1'b1;
              Bin <= '0;
            end else begin
              Err  <= 1'b0;
              cnt  <= '0;
              Busy <= 1'b1;
            end
          end
        end
        SHIFT: begin
          sr  <= sr_next;
          cnt <= cnt + CNT_W'(1);
          if (last_shift) Busy <= 1'b0;
        end
        DONE: begin
          Done <= 1'b1;
          // Error path already forced Bin to zero at load.
          if (!Err) Bin <= result;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// Directed self-checking bench for bcd_to_bin_seq (default DIGITS=2, BIN_W=7).
module tb_bcd_to_bin_seq;

  logic       Clock;
  logic       Resetn;
  logic       Start;
  logic [7:0] BCD;
`ifdef BCD2BIN_CARRY_IN_EN
  logic       Cin;
`endif
  logic [6:0] Bin;
  logic       Busy;
  logic       Done;
  logic       Err;
  logic [1:0] dbg_state;

  int n_tests = 0;
  int n_fail  = 0;
  logic [6:0] exp_q[$];

  bcd_to_bin_seq #(.DIGITS(2), .BIN_W(7)) dut (
    .Clock     (Clock),
    .Resetn    (Resetn),
    .Start     (Start),
    .BCD       (BCD),
`ifdef BCD2BIN_CARRY_IN_EN
    .Cin       (Cin),
`endif
    .Bin       (Bin),
    .Busy      (Busy),
    .Done      (Done),
    .Err       (Err),
    .dbg_state (dbg_state)
  );

  // Clock / reset
  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Driver tasks
  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Issue one Start pulse and watch for Done; scoreboard supplies the expected Bin.
  task automatic run_conv(input string tag, input logic [7:0] bcd, input logic [6:0] exp_bin,
                          input logic exp_err, input int exp_lat, input int exp_busy);
    int lat;
    int busy;
    bit seen;
    logic [6:0] exp_bin_q;
    BCD   = bcd;
    Start = 1'b1;
    exp_q.push_back(exp_bin);
    tick();
    Start = 1'b0;
    lat  = 0;
    busy = Busy ? 1 : 0;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick();
      lat++;
      if (Done) seen = 1'b1;
      else if (Busy) busy++;
    end
    exp_bin_q = exp_q.pop_front();
    check({tag, "_done_seen"}, 32'(seen), 1);
    check({tag, "_latency"}, lat, exp_lat);
    check({tag, "_busy_cycles"}, busy, exp_busy);
    check({tag, "_bin"}, Bin, exp_bin_q);
    check({tag, "_err"}, Err, exp_err);
    tick();
    check({tag, "_done_pulse_1cyc"}, Done, 0);
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int dones;
    int t1;
    int t2;
    Resetn = 1'b0;
    Start  = 1'b1;
    BCD    = 8'h99;
`ifdef BCD2BIN_CARRY_IN_EN
    Cin    = 1'b0;
`endif
    // Reset holds everything at zero even with Start high
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_bin", Bin, 0);
      check("rst_busy", Busy, 0);
      check("rst_done", Done, 0);
      check("rst_err", Err, 0);
      check("rst_state", dbg_state, 0);
    end
    Start = 1'b0;
    #2 Resetn = 1'b1;
    tick();

    run_conv("b47", 8'h47, 7'd47, 1'b0, 8, 7);
    for (int i = 0; i < 3; i++) tick();
    check("b47_hold", Bin, 47);
    check("b47_hold_done", Done, 0);

    run_conv("b00", 8'h00, 7'd0,  1'b0, 8, 7);
    run_conv("b99", 8'h99, 7'd99, 1'b0, 8, 7);
    run_conv("b10", 8'h10, 7'd10, 1'b0, 8, 7);

    run_conv("e3a", 8'h3A, 7'd0,  1'b1, 1, 0);
    run_conv("b25", 8'h25, 7'd25, 1'b0, 8, 7);

    // Start re-pulsed and digits changed while busy: ignored
    BCD   = 8'h63;
    Start = 1'b1;
    tick();
    Start = 1'b0;
    tick();
    tick();
    BCD   = 8'h12;
    Start = 1'b1;
    tick();
    Start = 1'b0;
    dones = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (Done) dones++;
    end
    check("ignore_done_count", dones, 1);
    check("ignore_bin", Bin, 63);
    check("ignore_err", Err, 0);

    // Constant Start gives back-to-back conversions every BIN_W + 2 cycles
    BCD   = 8'h21;
    Start = 1'b1;
    tick();
    t1 = -1;
    t2 = -1;
    for (int i = 1; i <= 40 && t2 < 0; i++) begin
      tick();
      if (Done) begin
        if (t1 < 0) t1 = i;
        else        t2 = i;
      end
    end
    Start = 1'b0;
    check("b2b_first_lat", t1, 8);
    check("b2b_period", t2 - t1, 9);
    check("b2b_bin", Bin, 21);
    for (int i = 0; i < 12; i++) tick();

    // Asynchronous abort in the middle of a conversion
    BCD   = 8'h58;
    Start = 1'b1;
    tick();
    Start = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    #2 Resetn = 1'b0;
    #1;
    check("abort_bin", Bin, 0);
    check("abort_busy", Busy, 0);
    check("abort_done", Done, 0);
    check("abort_err", Err, 0);
    check("abort_state", dbg_state, 0);
    #2 Resetn = 1'b1;
    dones = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (Done) dones++;
    end
    check("abort_no_done", dones, 0);
    check("abort_bin_after", Bin, 0);

`ifdef BCD2BIN_CARRY_IN_EN
    Cin = 1'b1;
    run_conv("c99", 8'h99, 7'd100, 1'b0, 8, 7);
    run_conv("c47", 8'h47, 7'd48,  1'b0, 8, 7);
    run_conv("cf0", 8'hF0, 7'd0,   1'b1, 1, 0);
    Cin = 1'b0;
`endif

    // Final report
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
